// File: rtl/prover_compute_v_seq.sv
// prover_compute_v_seq: drives one prover_compute_v through a restart pass and one update pass per
// verifier challenge, deriving 1 - tau mod F_Q and flagging per-round evaluations and the final value.
module prover_compute_v_seq #(
   parameter int ngates = 8,
   parameter int nrounds = $clog2(ngates),
   parameter int F_NBITS = 61,
   parameter logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}},
   localparam int rw = (nrounds > 0) ? $clog2(nrounds + 1) : 1
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               start,
   input  logic [F_NBITS-1:0] tau_in,
   input  logic               tau_valid,
   output logic               tau_ready,
   output logic               cv_en,
   output logic               cv_restart,
   output logic               cv_skip012,
   output logic [F_NBITS-1:0] cv_tau,
   output logic [F_NBITS-1:0] cv_m_tau_p1,
   input  logic               cv_ready_pulse,
   output logic               evals_valid,
   output logic [rw-1:0]      round,
   output logic               final_valid,
   output logic               busy
);

   if (nrounds != $clog2(ngates)) begin : g_bad_nrounds
      $error("nrounds is derived from ngates and must not be overridden");
   end
   if (ngates < 2) begin : g_bad_ngates
      $error("ngates must be at least 2");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_KICK, ST_WAIT, ST_TAU} state_t;

   state_t state, state_n;
   logic restart_n, skip_n, en_n, evals_n, final_n, busy_n, last;
   logic [F_NBITS-1:0] tau_n, m_tau_n, m_tau;
   logic [F_NBITS:0] q_minus;
   logic [rw-1:0] round_n;

   // F_Q + 1 - tau wraps for tau = 0 and equals F_Q for tau = 1, so both are pinned explicitly
   assign q_minus = {1'b0, F_Q} + (F_NBITS + 1)'(1) - {1'b0, tau_in};
   assign m_tau = (tau_in == '0) ? F_NBITS'(1) : (tau_in == F_NBITS'(1)) ? '0 : q_minus[F_NBITS-1:0];
   assign last = round == rw'(nrounds - 1);

   always_comb begin
      state_n = state;
      restart_n = cv_restart;
      skip_n = cv_skip012;
      tau_n = cv_tau;
      m_tau_n = cv_m_tau_p1;
      round_n = round;
      busy_n = busy;
      en_n = 1'b0;
      evals_n = 1'b0;
      final_n = 1'b0;
      case (state)
         ST_IDLE: begin
            busy_n = start & ~busy;
            if (start && !busy) begin
               state_n = ST_KICK;
               restart_n = 1'b1;
               skip_n = 1'b0;
               round_n = '0;
            end
         end
         ST_KICK: begin
            en_n = 1'b1;
            state_n = ST_WAIT;
         end
         ST_WAIT: if (cv_ready_pulse) begin
            evals_n = ~cv_skip012;
            final_n = cv_skip012;
            state_n = cv_skip012 ? ST_IDLE : ST_TAU;
         end
         ST_TAU: if (tau_valid) begin
            tau_n = tau_in;
            m_tau_n = m_tau;
            restart_n = 1'b0;
            skip_n = last;
            round_n = last ? round : round + 1'b1;
            state_n = ST_KICK;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= ST_IDLE;
         tau_ready <= 1'b0;
         cv_en <= 1'b0;
         cv_restart <= 1'b0;
         cv_skip012 <= 1'b0;
         cv_tau <= '0;
         cv_m_tau_p1 <= '0;
         evals_valid <= 1'b0;
         round <= '0;
         final_valid <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         tau_ready <= state_n == ST_TAU;
         cv_en <= en_n;
         cv_restart <= restart_n;
         cv_skip012 <= skip_n;
         cv_tau <= tau_n;
         cv_m_tau_p1 <= m_tau_n;
         evals_valid <= evals_n;
         round <= round_n;
         final_valid <= final_n;
         busy <= busy_n;
      end
   end

endmodule

// File: tb/tb_prover_compute_v_seq.sv
// tb_prover_compute_v_seq: randomized bench for prover_compute_v_seq with behavioural engine models
// and a direct multilinear-evaluation reference for the final reduced value.
`timescale 1ns/1ps
module tb_prover_compute_v_seq;
   localparam int NB = 61;
   localparam logic [NB-1:0] Q = 61'h1FFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0, rstb = 1'b0;
   always #5 clk = ~clk;

   logic start, tau_valid, tau_ready, cv_en, cv_restart, cv_skip012, cv_ready_pulse;
   logic evals_valid, final_valid, busy;
   logic [NB-1:0] tau_in, cv_tau, cv_m_tau_p1;
   logic [1:0] round;

   logic start2, tv2, tr2, en2, rs2, sk2, rp2, rp2_d, ev2, fv2, busy2;
   logic [NB-1:0] t2, ct2, cm2;
   logic [1:0] rd2;

   prover_compute_v_seq #(.ngates(8), .F_NBITS(NB), .F_Q(Q)) dut (
      .clk(clk), .rstb(rstb), .start(start), .tau_in(tau_in), .tau_valid(tau_valid),
      .tau_ready(tau_ready), .cv_en(cv_en), .cv_restart(cv_restart), .cv_skip012(cv_skip012),
      .cv_tau(cv_tau), .cv_m_tau_p1(cv_m_tau_p1), .cv_ready_pulse(cv_ready_pulse),
      .evals_valid(evals_valid), .round(round), .final_valid(final_valid), .busy(busy));

   prover_compute_v_seq #(.ngates(5), .F_NBITS(NB), .F_Q(Q)) dut5 (
      .clk(clk), .rstb(rstb), .start(start2), .tau_in(t2), .tau_valid(tv2),
      .tau_ready(tr2), .cv_en(en2), .cv_restart(rs2), .cv_skip012(sk2),
      .cv_tau(ct2), .cv_m_tau_p1(cm2), .cv_ready_pulse(rp2),
      .evals_valid(ev2), .round(rd2), .final_valid(fv2), .busy(busy2));

   int checks = 0, errors = 0, en_wide = 0, lat_err = 0, lat_cnt = 0;
   logic prev_en = 1'b0, prev_rp = 1'b0;
   logic [1:0] en_rs[$];
   logic [NB-1:0] en_tau[$], en_m[$], tq[$];
   int ev_round[$];
   logic [NB-1:0] vin[8], vv[8];

   function automatic logic [NB-1:0] mm(input logic [NB-1:0] a, input logic [NB-1:0] b);
      logic [2*NB-1:0] p;
      p = {{NB{1'b0}}, a} * {{NB{1'b0}}, b};
      return NB'(p % {{NB{1'b0}}, Q});
   endfunction

   function automatic logic [NB-1:0] addm(input logic [NB-1:0] a, input logic [NB-1:0] b);
      logic [NB:0] s;
      s = {1'b0, a} + {1'b0, b};
      return NB'(s % {1'b0, Q});
   endfunction

   function automatic logic [NB-1:0] sub1(input logic [NB-1:0] t);
      return addm(NB'(1), NB'(({1'b0, Q} - {1'b0, t}) % {1'b0, Q}));
   endfunction

   function automatic logic [NB-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return NB'(r % {3'b0, Q});
   endfunction

   // engine for the 8-gate instance: one ready pulse 1..4 cycles after each enable
   always @(posedge clk or negedge rstb)
      if (!rstb) begin
         lat_cnt <= 0;
         cv_ready_pulse <= 1'b0;
      end else begin
         cv_ready_pulse <= lat_cnt == 1;
         if (cv_en) lat_cnt <= int'($urandom_range(1, 4));
         else if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
      end

   // engine for the 5-gate instance: loads on restart, otherwise folds pairs with (1-tau, tau)
   always @(posedge clk or negedge rstb)
      if (!rstb) begin
         rp2_d <= 1'b0;
         rp2 <= 1'b0;
      end else begin
         rp2_d <= en2;
         rp2 <= rp2_d;
         if (en2 && rs2) for (int i = 0; i < 8; i++) vv[i] <= vin[i];
         if (en2 && !rs2) begin
            for (int i = 0; i < 4; i++) vv[i] <= addm(mm(vv[2*i], cm2), mm(vv[2*i+1], ct2));
            for (int i = 4; i < 8; i++) vv[i] <= '0;
         end
      end

   always @(negedge clk) begin
      prev_en <= cv_en;
      prev_rp <= cv_ready_pulse;
      if (cv_en && prev_en) en_wide <= en_wide + 1;
      if ((evals_valid | final_valid) != prev_rp) lat_err <= lat_err + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic run_layer(input bit do_start, input bit poke, input int stop_en,
                            output bit ok, output int k, output int first_en, output logic busy0);
      bit pend;
      pend = 0; ok = 0; k = 0; first_en = -1; busy0 = 1'b0;
      en_rs.delete(); en_tau.delete(); en_m.delete(); ev_round.delete();
      tau_in = (tq.size() > 0) ? tq[0] : '0;
      tau_valid = 1'b1;
      if (do_start) start = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 0) busy0 = busy;
         if (cv_en) begin
            if (first_en < 0) first_en = c;
            en_rs.push_back({cv_restart, cv_skip012});
            en_tau.push_back(cv_tau);
            en_m.push_back(cv_m_tau_p1);
         end
         if (evals_valid) begin
            ev_round.push_back(int'(round));
            if (poke && ev_round.size() == 1) start = 1'b1;
         end
         if (pend) begin
            k++;
            pend = 0;
            if (k < tq.size()) tau_in = tq[k];
         end
         if (tau_valid && tau_ready) pend = 1;
         if (final_valid) begin
            ok = 1;
            if (poke) start = 1'b1;
            break;
         end
         if (stop_en > 0 && en_rs.size() == stop_en) break;
      end
      tau_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if ({busy, cv_en, tau_ready, evals_valid, final_valid, cv_restart, cv_skip012} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {busy, cv_en, tau_ready, evals_valid, final_valid, cv_restart, cv_skip012}); end
      checks++; if ({cv_tau, cv_m_tau_p1, round} !== '0) begin errors++; $display("FAIL reset_data: got tau %0h m %0h round %0d expected 0", cv_tau, cv_m_tau_p1, round); end
      rstb = 1'b1;
      tau_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (tau_ready !== 1'b0 || busy !== 1'b0 || cv_en !== 1'b0) begin errors++; $display("FAIL idle_no_tau: got ready %b busy %b en %b expected 0", tau_ready, busy, cv_en); end
      tau_valid = 1'b0;
   endtask

   task automatic test_basic_layer;
      bit ok; int k, fe; logic b0;
      tq = '{61'd5, 61'd7, 61'd9};
      run_layer(1'b1, 1'b0, 0, ok, k, fe, b0);
      checks++; if (!ok) begin errors++; $display("FAIL basic_final: got no final_valid expected one"); end
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", b0); end
      checks++; if (fe != 1) begin errors++; $display("FAIL basic_start_latency: got %0d expected 1", fe); end
      checks++; if (en_rs.size() != 4 || en_rs[0] !== 2'b10 || en_rs[1] !== 2'b00 || en_rs[2] !== 2'b00 || en_rs[3] !== 2'b01) begin errors++; $display("FAIL basic_passes: got %0d passes %b %b %b %b expected 10 00 00 01", en_rs.size(), en_rs[0], en_rs[1], en_rs[2], en_rs[3]); end
      checks++; if (ev_round.size() != 3 || ev_round[0] != 0 || ev_round[1] != 1 || ev_round[2] != 2) begin errors++; $display("FAIL basic_rounds: got %0d evals expected rounds 0 1 2", ev_round.size()); end
      checks++; if (k != 3) begin errors++; $display("FAIL basic_taus: got %0d expected 3", k); end
      checks++; if (en_tau[1] !== 61'd5 || en_tau[2] !== 61'd7 || en_tau[3] !== 61'd9 || cv_tau !== 61'd9) begin errors++; $display("FAIL basic_tau_values: got %0d %0d %0d expected 5 7 9", en_tau[1], en_tau[2], en_tau[3]); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || final_valid !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got busy %b final %b expected 0", busy, final_valid); end
      @(negedge clk);
   endtask

   task automatic test_m_tau;
      bit ok; int k, fe; logic b0;
      tq = '{61'd0, 61'd1, Q - 61'd1};
      run_layer(1'b1, 1'b0, 0, ok, k, fe, b0);
      checks++; if (!ok || en_m[1] !== 61'd1 || en_m[2] !== 61'd0 || en_m[3] !== 61'd2) begin errors++; $display("FAIL m_tau_edges: got %0h %0h %0h expected 1 0 2", en_m[1], en_m[2], en_m[3]); end
      repeat (2) @(negedge clk);
      tq.delete();
      for (int i = 0; i < 3; i++) tq.push_back(rnd());
      run_layer(1'b1, 1'b0, 0, ok, k, fe, b0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (en_tau[i+1] !== tq[i] || en_m[i+1] !== sub1(tq[i])) begin errors++; $display("FAIL m_tau_random: got tau %0h m %0h expected tau %0h m %0h", en_tau[i+1], en_m[i+1], tq[i], sub1(tq[i])); end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_stall;
      bit ok; int k, fe, bad; logic b0, c1, c2; logic [NB-1:0] mt;
      mt = rnd();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = tau_ready;
      end
      checks++; if (!ok) begin errors++; $display("FAIL stall_ready: got tau_ready 0 expected 1"); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tau_ready !== 1'b1 || cv_en !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
      tau_in = mt;
      tau_valid = 1'b1;
      @(negedge clk);
      tau_valid = 1'b0;
      c1 = cv_en;
      @(negedge clk);
      c2 = cv_en;
      checks++; if ({c1, c2} !== 2'b01) begin errors++; $display("FAIL stall_resume: got en %b%b expected 01", c1, c2); end
      checks++; if (cv_tau !== mt || cv_m_tau_p1 !== sub1(mt) || cv_restart !== 1'b0) begin errors++; $display("FAIL stall_capture: got tau %0h m %0h expected tau %0h m %0h", cv_tau, cv_m_tau_p1, mt, sub1(mt)); end
      tq = '{rnd(), rnd()};
      run_layer(1'b0, 1'b0, 0, ok, k, fe, b0);
      checks++; if (!ok || k != 2 || en_rs.size() != 2 || en_rs[0] !== 2'b00 || en_rs[1] !== 2'b01) begin errors++; $display("FAIL stall_finish: got ok %0d taus %0d passes %0d expected 1 2 2", ok, k, en_rs.size()); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_ignored;
      bit ok; int k, fe; logic b0;
      tq = '{rnd(), rnd(), rnd()};
      run_layer(1'b1, 1'b1, 0, ok, k, fe, b0);
      checks++; if (!ok || en_rs.size() != 4) begin errors++; $display("FAIL ignore_mid_start: got %0d passes expected 4", en_rs.size()); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0 || cv_en !== 1'b0) begin errors++; $display("FAIL ignore_final_start: got busy %b expected 0", busy); end
      run_layer(1'b1, 1'b0, 0, ok, k, fe, b0);
      checks++; if (!ok || fe != 1 || en_rs.size() != 4 || en_rs[0] !== 2'b10) begin errors++; $display("FAIL restart_after_busy: got first_en %0d passes %0d first %b expected 1 4 10", fe, en_rs.size(), en_rs[0]); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit ok; int k, fe; logic b0;
      tq = '{rnd(), rnd(), rnd()};
      run_layer(1'b1, 1'b0, 2, ok, k, fe, b0);
      checks++; if (en_rs.size() != 2 || round !== 2'd1) begin errors++; $display("FAIL reset_mid_setup: got passes %0d round %0d expected 2 1", en_rs.size(), round); end
      #1 rstb = 1'b0;
      #1;
      checks++; if ({busy, cv_en, tau_ready, evals_valid, final_valid, cv_restart, cv_skip012, cv_tau, cv_m_tau_p1, round} !== '0) begin errors++; $display("FAIL reset_mid_outputs: got busy %b restart %b tau %0h m %0h round %0d expected 0", busy, cv_restart, cv_tau, cv_m_tau_p1, round); end
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      tq = '{rnd(), rnd(), rnd()};
      run_layer(1'b1, 1'b0, 0, ok, k, fe, b0);
      checks++; if (!ok || en_rs[0] !== 2'b10 || ev_round.size() != 3 || ev_round[0] != 0) begin errors++; $display("FAIL reset_mid_restart: got first %b evals %0d round0 %0d expected 10 3 0", en_rs[0], ev_round.size(), ev_round[0]); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ref_model;
      logic [NB-1:0] t[3];
      logic [NB-1:0] exp_v, term;
      int k, nv;
      bit done;
      repeat (3) begin
         for (int i = 0; i < 8; i++) vin[i] = (i < 5) ? rnd() : '0;
         for (int j = 0; j < 3; j++) t[j] = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 1)) : rnd();
         exp_v = '0;
         for (int i = 0; i < 5; i++) begin
            term = vin[i];
            for (int j = 0; j < 3; j++) term = mm(term, ((i >> j) & 1) != 0 ? t[j] : sub1(t[j]));
            exp_v = addm(exp_v, term);
         end
         k = 0; nv = 0; done = 0;
         start2 = 1'b1;
         for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (ev2) nv++;
            if (fv2) done = 1;
            tv2 = 1'b0;
            if (tr2 && k < 3) begin
               tv2 = 1'b1;
               t2 = t[k];
               k++;
            end
         end
         tv2 = 1'b0;
         checks++; if (!done || nv != 3 || k != 3) begin errors++; $display("FAIL ref_counts: got final %0d evals %0d taus %0d expected 1 3 3", done, nv, k); end
         checks++; if (vv[0] !== exp_v || rd2 !== 2'd2 || sk2 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL ref_value: got %0h round %0d expected %0h round 2", vv[0], rd2, exp_v); end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_protocol;
      checks++; if (en_wide != 0) begin errors++; $display("FAIL en_width: got %0d wide pulses expected 0", en_wide); end
      checks++; if (lat_err != 0) begin errors++; $display("FAIL ready_latency: got %0d mismatched cycles expected 0", lat_err); end
   endtask

   initial begin
      start = 1'b0; tau_valid = 1'b0; tau_in = '0;
      start2 = 1'b0; tv2 = 1'b0; t2 = '0;
      test_reset;
      test_basic_layer;
      test_m_tau;
      test_stall;
      test_start_ignored;
      test_reset_mid;
      test_ref_model;
      test_protocol;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
